// File: rtl/multicast_stream_fork.sv
// Registered one-to-many stream fork: holds one request and offers it to every output selected by its mask.
// Optional MULTICAST_FORK_SERIAL_EN serves pending outputs one at a time in ascending index order.
module multicast_stream_fork #(
  parameter int unsigned NoOutputs = 32'd2,
  parameter type         data_t    = logic
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  data_t                data_i,
  input  logic [NoOutputs-1:0] mask_i,
  output logic                 drop_o,
  output logic                 busy_o,
  output logic [NoOutputs-1:0] valid_o,
  input  logic [NoOutputs-1:0] ready_i,
  output data_t                data_o
);

  typedef enum logic {
    EMPTY,
    FORK
  } state_e;

  state_e               state_q, state_d;
  logic [NoOutputs-1:0] pend_q, pend_d;
  data_t                data_q, data_d;
  logic [NoOutputs-1:0] sel;
  logic [NoOutputs-1:0] hs;
  logic [NoOutputs-1:0] rem;
  logic                 last;

`ifdef MULTICAST_FORK_SERIAL_EN
  // Offer only the lowest-index pending output.
  always_comb begin
    logic found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < NoOutputs; j++) begin
      if (pend_q[j] && !found) begin
        sel[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end
`else
  assign sel = pend_q;
`endif

  assign valid_o = (state_q == FORK) ? sel : '0;
  assign hs      = valid_o & ready_i;
  assign rem     = pend_q & ~hs;
  assign last    = (rem == '0);
  assign busy_o  = (state_q == FORK);
  assign data_o  = data_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    data_d  = data_q;
    ready_o = 1'b0;
    drop_o  = 1'b0;
    unique case (state_q)
      EMPTY: begin
        ready_o = 1'b1;
        if (valid_i) begin
          if (mask_i != '0) begin
            data_d  = data_i;
            pend_d  = mask_i;
            state_d = FORK;
          end else begin
            drop_o = 1'b1;
          end
        end
      end
      FORK: begin
        pend_d = rem;
        if (last) begin
          // Freed this cycle: a new request may overwrite the register with no bubble.
          ready_o = 1'b1;
          state_d = EMPTY;
          if (valid_i) begin
            if (mask_i != '0) begin
              data_d  = data_i;
              pend_d  = mask_i;
              state_d = FORK;
            end else begin
              drop_o = 1'b1;
            end
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      pend_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
    end
  end

endmodule
